uart_cmd_ctrl: RTL and testbench

Command sequencer between the UART ASCII command parser and an on-chip register/memory bank. It accepts one parsed command (read, write or failed parse) and runs the bank access with a req/ack handshake and an ack timeout. It then streams an ASCII response to the UART transmitter over a valid/ready byte handshake. It processes one command at a time; commands that arrive while busy are dropped and flagged.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_resp_gen.sv | 65 ++++++
 rtl/uart_cmd_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART command sequencer.
//   state_t   - sequencer FSM states
//   resp_t    - which ASCII response is being streamed
//   ASCII_*   - fixed response characters, CR/LF line terminator
//   hex_ascii - nibble to uppercase ASCII hex digit
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_LOAD,
    ST_SEND
  } state_t;

  typedef enum logic [1:0] {
    RESP_OK,
    RESP_ER,
    RESP_TO,
    RESP_RD
  } resp_t;

  localparam logic [7:0] ASCII_O = 8'h4F;
  localparam logic [7:0] ASCII_K = 8'h4B;
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_T = 8'h54;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_resp_gen.sv
// uart_resp_gen: combinational response byte selector.
//   resp      in  response type (OK / ER / TO / read data)
//   data      in  captured read data (used for RESP_RD only)
//   idx       in  byte index within the response
//   resp_byte out ASCII byte at idx
//   last      out idx addresses the final byte (LF) of the response
// Read responses are DATA_W/4 hex digits, MSB nibble first, then CR LF.
// All fixed responses are two letters followed by CR LF.
module uart_resp_gen
  import uart_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  resp_t             resp,
  input  logic [DATA_W-1:0] data,
  input  logic [IDX_W-1:0]  idx,
  output logic [7:0]        resp_byte,
  output logic              last
);

  localparam int NIB = DATA_W / 4;

  logic [3:0] nib;

  // Digit 0 is the most significant nibble.
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) nib = data[DATA_W-1-4*i -: 4];
    end
  end

  always_comb begin
    resp_byte = 8'h00;
    last      = 1'b0;
    if (resp == RESP_RD) begin
      if (idx < IDX_W'(NIB))       resp_byte = hex_ascii(nib);
      else if (idx == IDX_W'(NIB)) resp_byte = CR;
      else                         resp_byte = LF;
      last = (idx == IDX_W'(NIB + 1));
    end else begin
      case (idx)
        IDX_W'(0): begin
          case (resp)
            RESP_OK: resp_byte = ASCII_O;
            RESP_ER: resp_byte = ASCII_E;
            default: resp_byte = ASCII_T;
          endcase
        end
        IDX_W'(1): begin
          case (resp)
            RESP_OK: resp_byte = ASCII_K;
            RESP_ER: resp_byte = ASCII_R;
            default: resp_byte = ASCII_O;
          endcase
        end
        IDX_W'(2): resp_byte = CR;
        default:   resp_byte = LF;
      endcase
      last = (idx == IDX_W'(3));
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: sequences one parsed UART command into a bank access and
// streams the ASCII response back to the transmitter.
//   CLK, RST            clock, synchronous active-high reset
//   CMD_*               parsed command strobe and fields; CMD_DROP flags a
//                       command that arrived while busy
//   BUSY                high whenever the sequencer is not IDLE
//   MEM_*               bank req/ack interface with ack timeout
//   TX_VALID/DATA/READY response byte stream
// Handshake: a byte transfers on a rising edge where TX_VALID && TX_READY.
// While TX_VALID is high and TX_READY low, TX_DATA is held; the byte index
// only advances on a transfer. MEM_REQ is held with stable address, data and
// write enable until MEM_ACK (one-cycle strobe) or timeout.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  input  logic              CMD_WR,
  input  logic              CMD_FAIL,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic              CMD_DROP,
  output logic              BUSY,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              TX_VALID,
  output logic [7:0]        TX_DATA,
  input  logic              TX_READY
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = $clog2(NIB + 2);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  resp_t             resp_q, resp_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              drop_q;

  logic       accept, ack_hit, to_hit, tx_fire;
  logic [7:0] resp_byte;
  logic       resp_last;

  uart_resp_gen #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_resp_gen (
    .resp      (resp_q),
    .data      (rdata_q),
    .idx       (idx_q),
    .resp_byte (resp_byte),
    .last      (resp_last)
  );

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    accept  = 1'b0;
    ack_hit = 1'b0;
    to_hit  = 1'b0;
    tx_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          if (CMD_FAIL) begin
            state_d = ST_LOAD;
            resp_d  = RESP_ER;
          end else begin
            state_d = ST_ACCESS;
            accept  = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // Ack is tested first so it wins over a timeout on the same cycle.
        if (MEM_ACK) begin
          ack_hit = 1'b1;
          state_d = ST_LOAD;
          resp_d  = we_q ? RESP_OK : RESP_RD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          state_d = ST_LOAD;
          resp_d  = RESP_TO;
        end
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        if (TX_READY) begin
          tx_fire = 1'b1;
          if (resp_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      resp_q  <= RESP_OK;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= CMD_VALID && (state_q != ST_IDLE);
      if (accept) begin
        we_q    <= CMD_WR;
        addr_q  <= CMD_ADDR;
        wdata_q <= CMD_DATA;
        cnt_q   <= '0;
      end
      if (state_q == ST_ACCESS && !ack_hit && !to_hit) cnt_q <= cnt_q + CNT_W'(1);
      if (ack_hit && !we_q) rdata_q <= MEM_RDATA;
      if (state_q == ST_LOAD) idx_q <= '0;
      else if (tx_fire)       idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign MEM_REQ   = (state_q == ST_ACCESS);
  assign MEM_WE    = MEM_REQ && we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign TX_VALID  = (state_q == ST_SEND);
  assign TX_DATA   = TX_VALID ? resp_byte : 8'h00;
  assign CMD_DROP  = drop_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed bench for uart_cmd_ctrl with TIMEOUT=8.
module tb_uart_cmd_ctrl;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_wr = 1'b0;
  logic              cmd_fail = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_drop, busy, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b1;
  logic              rand_ready = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .CMD_VALID (cmd_valid),
    .CMD_WR    (cmd_wr),
    .CMD_FAIL  (cmd_fail),
    .CMD_ADDR  (cmd_addr),
    .CMD_DATA  (cmd_data),
    .CMD_DROP  (cmd_drop),
    .BUSY      (busy),
    .MEM_REQ   (mem_req),
    .MEM_WE    (mem_we),
    .MEM_ADDR  (mem_addr),
    .MEM_WDATA (mem_wdata),
    .MEM_RDATA (mem_rdata),
    .MEM_ACK   (mem_ack),
    .TX_VALID  (tx_valid),
    .TX_DATA   (tx_data),
    .TX_READY  (tx_ready)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard and monitors ----------------
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  logic              exp_we = 1'b0;
  int                req_cycles = 0;
  int                n_access = 0;
  int                drop_count = 0;
  logic              req_prev = 1'b0;
  logic              hold_pend = 1'b0;
  logic [7:0]        hold_data = 8'h00;
  logic [7:0]        exp_byte;

  always @(negedge clk) begin
    if (!rst && hold_pend) begin
      check("tx_hold_valid", tx_valid, 1);
      check("tx_hold_data", tx_data, hold_data);
    end
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_extra_byte", tx_data, 32'hFFFF_FFFF);
      end else begin
        exp_byte = exp_q.pop_front();
        check("tx_byte", tx_data, exp_byte);
      end
    end
    hold_pend = !rst && tx_valid && !tx_ready;
    hold_data = tx_data;
    if (!rst && mem_req) begin
      req_cycles++;
      if (!req_prev) n_access++;
      check("req_addr", mem_addr, exp_addr);
      check("req_wdata", mem_wdata, exp_wdata);
      check("req_we", mem_we, exp_we);
    end
    req_prev = !rst && mem_req;
    if (!rst && cmd_drop) drop_count++;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic wr, input logic fail,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_fail  = fail;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_fail  = 1'b0;
  endtask

  // Ack after n idle cycles, then check req drop and two-cycle TX latency.
  task automatic ack_after(input int n, input logic [DATA_W-1:0] rdata);
    repeat (n) @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("ack_req_drop", mem_req, 0);
    check("ack_gap_valid", tx_valid, 0);
    @(posedge clk); #1;
    check("ack_tx_latency", tx_valid, 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_done", (exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int acc0, drop0;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 0);
    check("rst_drop", cmd_drop, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    // 1: write, ack after 3 cycles -> OK
    exp_addr = 8'h12; exp_wdata = 32'hDEADBEEF; exp_we = 1'b1;
    push4(8'h4F, 8'h4B, 8'h0D, 8'h0A);
    req_cycles = 0;
    send_cmd(1'b1, 1'b0, 8'h12, 32'hDEADBEEF);
    check("t1_req_latency", mem_req, 1);
    check("t1_busy", busy, 1);
    ack_after(3, 32'h0);
    wait_done(50);
    check("t1_req_cycles", req_cycles, 4);

    // 2: read with random TX_READY -> hex digits
    exp_addr = 8'h05; exp_wdata = 32'h0; exp_we = 1'b0;
    push4(8'h30, 8'h31, 8'h32, 8'h33);
    push4(8'h41, 8'h42, 8'h43, 8'h44);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    send_cmd(1'b0, 1'b0, 8'h05, 32'h0);
    check("t2_req_latency", mem_req, 1);
    check("t2_we", mem_we, 0);
    rand_ready = 1'b1;
    ack_after(2, 32'h0123ABCD);
    wait_done(400);
    rand_ready = 1'b0;
    @(posedge clk); #1;
    tx_ready = 1'b1;

    // 3: parser failure -> ER, no access
    acc0 = n_access;
    push4(8'h45, 8'h52, 8'h0D, 8'h0A);
    send_cmd(1'b0, 1'b1, 8'h44, 32'h0);
    check("t3_busy", busy, 1);
    check("t3_no_req", mem_req, 0);
    wait_done(50);
    check("t3_no_access", n_access - acc0, 0);

    // 4: read without ack -> TO after exactly TIMEOUT cycles
    exp_addr = 8'h33; exp_wdata = 32'h0; exp_we = 1'b0;
    push4(8'h54, 8'h4F, 8'h0D, 8'h0A);
    req_cycles = 0;
    send_cmd(1'b0, 1'b0, 8'h33, 32'h0);
    wait_done(80);
    check("t4_req_cycles", req_cycles, TIMEOUT);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    check("t4_late_ack_busy", busy, 0);
    check("t4_late_ack_req", mem_req, 0);

    // 5: commands during ACCESS and SEND are dropped
    exp_addr = 8'h40; exp_wdata = 32'h11223344; exp_we = 1'b1;
    push4(8'h4F, 8'h4B, 8'h0D, 8'h0A);
    acc0 = n_access;
    drop0 = drop_count;
    tx_ready = 1'b0;
    send_cmd(1'b1, 1'b0, 8'h40, 32'h11223344);
    send_cmd(1'b0, 1'b0, 8'h99, 32'hCAFEF00D);
    check("t5_drop_access", cmd_drop, 1);
    @(posedge clk); #1;
    check("t5_drop_oneshot", cmd_drop, 0);
    ack_after(1, 32'h0);
    send_cmd(1'b0, 1'b0, 8'h77, 32'h0);
    check("t5_drop_send", cmd_drop, 1);
    tx_ready = 1'b1;
    wait_done(50);
    check("t5_drop_count", drop_count - drop0, 2);
    check("t5_one_access", n_access - acc0, 1);

    // 6: reset in the middle of a read response
    exp_addr = 8'h21; exp_wdata = 32'h0; exp_we = 1'b0;
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h46);
    send_cmd(1'b0, 1'b0, 8'h21, 32'h0);
    ack_after(1, 32'hCAFE0000);
    repeat (3) @(posedge clk);
    #1;
    check("t6_three_bytes", exp_q.size(), 0);
    rst = 1'b1;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_txv", tx_valid, 0);
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_txd", tx_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_ready = 1'b1;
    exp_addr = 8'h7E; exp_wdata = 32'hA5A5A5A5; exp_we = 1'b1;
    push4(8'h4F, 8'h4B, 8'h0D, 8'h0A);
    send_cmd(1'b1, 1'b0, 8'h7E, 32'hA5A5A5A5);
    check("t6_req_latency", mem_req, 1);
    ack_after(0, 32'h0);
    wait_done(50);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
